// File: rtl/cdb_pkg.sv
// cdb_pkg: shared requester indices, widths, entry type and rotation helper for cdb_arbiter
package cdb_pkg;
  localparam int NUM_REQ = 3;
  localparam int REQ_ALU = 0;
  localparam int REQ_BRU = 1;
  localparam int REQ_LSU = 2;
  localparam int ROB_ID_W = 5;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   value;
  } cdb_entry_t;
  // Requester index at position k of the rotation that starts at ptr
  function automatic logic [1:0] rot_idx(input logic [1:0] ptr, input int k);
    int j;
    j = int'(ptr) + k;
    return 2'(j >= NUM_REQ ? j - NUM_REQ : j);
  endfunction
endpackage

// File: rtl/cdb_req_fifo.sv
// cdb_req_fifo: per-requester result queue with flush, simultaneous push/pop allowed
module cdb_req_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 37
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign head = mem_q[rd_q];
  // Flush empties the queue; otherwise push and pop advance their own pointers
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = flush ? '0 : push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d = flush ? '0 : pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  // Queue state registers
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: ALU/BRU/LSU result queues merged onto two CDB ports; define CDB_ARB_ROUND_ROBIN_EN for round-robin, else fixed LSU > ALU > BRU
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_ID_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  _clear,
  input  logic [2:0]            _req_valid,
  input  logic [3*ROB_ID_W-1:0] _req_rob_id,
  input  logic [3*DATA_W-1:0]   _req_value,
  output logic [2:0]            _req_ready,
  output logic                  _cdb_ready,
  output logic [ROB_ID_W-1:0]   _cdb_rob_id,
  output logic [DATA_W-1:0]     _cdb_value,
  output logic                  _cdb_ls_ready,
  output logic [ROB_ID_W-1:0]   _cdb_ls_rob_id,
  output logic [DATA_W-1:0]     _cdb_ls_value
);
  import cdb_pkg::*;
  localparam int W = ROB_ID_W + DATA_W;
  logic [W-1:0]       head [NUM_REQ];
  logic [NUM_REQ-1:0] full, empty, push, pop;
  logic               go, flush, g0_v, g1_v;
  logic [1:0]         g0, g1;
  logic               cdb_v_q, cdb_v_d, ls_v_q, ls_v_d;
  logic [W-1:0]       cdb_q, cdb_d, ls_q, ls_d;
  assign go = rdy_in && !_clear;
  assign flush = rdy_in && _clear;
  assign _req_ready = ~full;
  assign push = go ? _req_valid & ~full : '0;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_q
    assign pop[i] = go && ((g0_v && g0 == 2'(i)) || (g1_v && g1 == 2'(i)));
    cdb_req_fifo #(.DEPTH(FIFO_DEPTH), .W(W)) u_fifo (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .flush    (flush),
      .push     (push[i]),
      .pop      (pop[i]),
      .din      ({_req_rob_id[i*ROB_ID_W +: ROB_ID_W], _req_value[i*DATA_W +: DATA_W]}),
      .full     (full[i]),
      .empty    (empty[i]),
      .head     (head[i])
    );
  end
`ifdef CDB_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_q, rr_d, c;
  // Scan heads from rr_ptr: first non-empty wins port 0, next non-empty ALU/LSU wins port 1
  always_comb begin
    g0_v = 1'b0;
    g0 = '0;
    g1_v = 1'b0;
    g1 = '0;
    c = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = rot_idx(rr_q, k);
      if (!empty[c] && !g0_v) begin
        g0_v = 1'b1;
        g0 = c;
      end else if (!empty[c] && !g1_v && c != 2'(REQ_BRU)) begin
        g1_v = 1'b1;
        g1 = c;
      end
    end
    rr_d = flush ? '0 : (go && g0_v) ? rot_idx(g0, 1) : rr_q;
  end
  // Rotation pointer
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) rr_q <= '0;
    else rr_q <= rr_d;
`else
  // Fixed priority: LSU > ALU > BRU on port 0; port 1 gets ALU only when LSU took port 0
  always_comb begin
    g0_v = |(~empty);
    g0 = !empty[REQ_LSU] ? 2'(REQ_LSU) : !empty[REQ_ALU] ? 2'(REQ_ALU) : 2'(REQ_BRU);
    g1_v = !empty[REQ_LSU] && !empty[REQ_ALU];
    g1 = 2'(REQ_ALU);
  end
`endif
  // Winners load the broadcast registers; idle ports drop valid and keep tag/value
  always_comb begin
    cdb_v_d = rdy_in ? go && g0_v : cdb_v_q;
    ls_v_d = rdy_in ? go && g1_v : ls_v_q;
    cdb_d = (go && g0_v) ? head[g0] : cdb_q;
    ls_d = (go && g1_v) ? head[g1] : ls_q;
  end
  // Broadcast registers
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      cdb_v_q <= 1'b0;
      ls_v_q <= 1'b0;
      cdb_q <= '0;
      ls_q <= '0;
    end else begin
      cdb_v_q <= cdb_v_d;
      ls_v_q <= ls_v_d;
      cdb_q <= cdb_d;
      ls_q <= ls_d;
    end
  assign _cdb_ready = cdb_v_q;
  assign _cdb_ls_ready = ls_v_q;
  assign {_cdb_rob_id, _cdb_value} = cdb_q;
  assign {_cdb_ls_rob_id, _cdb_ls_value} = ls_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized scoreboard bench for cdb_arbiter against a queue-level reference model
module tb_cdb_arbiter;
  import cdb_pkg::*;
  localparam int DEPTH = 2;
  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic        _clear = 1'b0;
  logic [2:0]  _req_valid = '0;
  logic [14:0] _req_rob_id = '0;
  logic [95:0] _req_value = '0;
  logic [2:0]  _req_ready;
  logic        _cdb_ready, _cdb_ls_ready;
  logic [4:0]  _cdb_rob_id, _cdb_ls_rob_id;
  logic [31:0] _cdb_value, _cdb_ls_value;
  int total = 0;
  int bad = 0;
  cdb_entry_t mq[3][$];
  cdb_entry_t exp0[$];
  cdb_entry_t exp1[$];
  logic m_r0 = 1'b0;
  logic m_r1 = 1'b0;
  int rr = 0;

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(.FIFO_DEPTH(DEPTH), .ROB_ID_W(5), .DATA_W(32)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    ._clear         (_clear),
    ._req_valid     (_req_valid),
    ._req_rob_id    (_req_rob_id),
    ._req_value     (_req_value),
    ._req_ready     (_req_ready),
    ._cdb_ready     (_cdb_ready),
    ._cdb_rob_id    (_cdb_rob_id),
    ._cdb_value     (_cdb_value),
    ._cdb_ls_ready  (_cdb_ls_ready),
    ._cdb_ls_rob_id (_cdb_ls_rob_id),
    ._cdb_ls_value  (_cdb_ls_value)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [14:0] ids(input int a, input int b, input int c);
    return {5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [95:0] vals(input int a, input int b, input int c);
    return {32'(c), 32'(b), 32'(a)};
  endfunction

  // Reference step: grants from queue heads in scan order, then accepts against pre-edge occupancy
  task automatic model_step();
    int order[3];
    int p0, p1;
    bit acc[3];
`ifdef CDB_ARB_ROUND_ROBIN_EN
    order = '{rr, (rr + 1) % 3, (rr + 2) % 3};
`else
    order = '{2, 0, 1};
`endif
    p0 = -1;
    p1 = -1;
    for (int k = 0; k < 3; k++)
      if (mq[order[k]].size() > 0) begin
        if (p0 < 0) p0 = order[k];
        else if (p1 < 0 && order[k] != 1) p1 = order[k];
      end
    for (int i = 0; i < 3; i++) acc[i] = _req_valid[i] && (mq[i].size() < DEPTH);
    m_r0 = p0 >= 0;
    m_r1 = p1 >= 0;
    if (p0 >= 0) exp0.push_back(mq[p0].pop_front());
    if (p1 >= 0) exp1.push_back(mq[p1].pop_front());
    for (int i = 0; i < 3; i++)
      if (acc[i]) mq[i].push_back({_req_rob_id[i*5 +: 5], _req_value[i*32 +: 32]});
`ifdef CDB_ARB_ROUND_ROBIN_EN
    if (p0 >= 0) rr = (p0 == 2) ? 0 : p0 + 1;
`endif
  endtask

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      exp0.delete();
      exp1.delete();
      m_r0 = 1'b0;
      m_r1 = 1'b0;
      rr = 0;
    end else if (rdy_in) begin
      if (_clear) begin
        for (int i = 0; i < 3; i++) mq[i].delete();
        m_r0 = 1'b0;
        m_r1 = 1'b0;
        rr = 0;
      end else model_step();
    end
  end

  // Monitor: flags and readiness every cycle; broadcasts checked against the scoreboard, consumed on rdy-high cycles
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      chk("p0_valid", 64'(_cdb_ready), 64'(m_r0));
      chk("p1_valid", 64'(_cdb_ls_ready), 64'(m_r1));
      chk("req_ready", 64'(_req_ready),
          64'({mq[2].size() < DEPTH, mq[1].size() < DEPTH, mq[0].size() < DEPTH}));
      if (_cdb_ready) begin
        if (exp0.size() == 0) begin
          total++;
          bad++;
          $display("FAIL p0_pending actual=broadcast required=none t=%0t", $time);
        end else begin
          chk("p0_tag", 64'(_cdb_rob_id), 64'(exp0[0].rob_id));
          chk("p0_value", 64'(_cdb_value), 64'(exp0[0].value));
          if (rdy_in) void'(exp0.pop_front());
        end
      end
      if (_cdb_ls_ready) begin
        if (exp1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL p1_pending actual=broadcast required=none t=%0t", $time);
        end else begin
          chk("p1_tag", 64'(_cdb_ls_rob_id), 64'(exp1[0].rob_id));
          chk("p1_value", 64'(_cdb_ls_value), 64'(exp1[0].value));
          if (rdy_in) void'(exp1.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic [2:0] v, input logic [14:0] id, input logic [95:0] val,
                     input logic r, input logic c);
    _req_valid = v;
    _req_rob_id = id;
    _req_value = val;
    rdy_in = r;
    _clear = c;
    @(posedge clk_in);
    #1;
    _req_valid = '0;
    _clear = 1'b0;
    rdy_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(3'b000, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_p0_valid", 64'(_cdb_ready), 0);
    chk("rst_p1_valid", 64'(_cdb_ls_ready), 0);
    chk("rst_p0_tag", 64'(_cdb_rob_id), 0);
    chk("rst_p0_value", 64'(_cdb_value), 0);
    chk("rst_p1_tag", 64'(_cdb_ls_rob_id), 0);
    rst_n_in = 1'b1;
    rdy_in = 1'b1;
    #1;
    chk("rst_req_ready", 64'(_req_ready), 64'(3'b111));
    cyc(3'b001, ids(3, 0, 0), vals(32'h10, 0, 0), 1'b1, 1'b0);
    idle(3);
    cyc(3'b111, ids(1, 2, 3), vals(101, 102, 103), 1'b1, 1'b0);
    idle(4);
    cyc(3'b010, ids(0, 4, 0), vals(0, 204, 0), 1'b1, 1'b0);
    cyc(3'b010, ids(0, 5, 0), vals(0, 205, 0), 1'b1, 1'b0);
    idle(4);
    for (int n = 0; n < 4; n++)
      cyc(3'b111, ids(7 + n, 20 + n, 24 + n), vals(300 + n, 310 + n, 320 + n), 1'b1, 1'b0);
    idle(6);
    cyc(3'b011, ids(11, 12, 0), vals(401, 402, 0), 1'b1, 1'b0);
    cyc(3'b111, ids(13, 14, 15), vals(403, 404, 405), 1'b1, 1'b1);
    idle(3);
    chk("clr_req_ready", 64'(_req_ready), 64'(3'b111));
    cyc(3'b001, ids(6, 0, 0), vals(406, 0, 0), 1'b1, 1'b0);
    idle(3);
    cyc(3'b001, ids(9, 0, 0), vals(509, 0, 0), 1'b1, 1'b0);
    cyc(3'b001, ids(10, 0, 0), vals(510, 0, 0), 1'b1, 1'b0);
    chk("hold_start_tag", 64'(_cdb_rob_id), 9);
    repeat (3) cyc(3'b000, '0, '0, 1'b0, 1'b0);
    chk("hold_end_tag", 64'(_cdb_rob_id), 9);
    idle(4);
    cyc(3'b001, ids(12, 0, 0), vals(612, 0, 0), 1'b1, 1'b0);
    idle(1);
    chk("pre_rst_valid", 64'(_cdb_ready), 1);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("async_rst_p0", 64'(_cdb_ready), 0);
    chk("async_rst_p1", 64'(_cdb_ls_ready), 0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    #1;
    chk("post_rst_req_ready", 64'(_req_ready), 64'(3'b111));
    for (int n = 0; n < 400; n++)
      cyc(3'($urandom_range(0, 7)), 15'($urandom), {$urandom, $urandom, $urandom},
          $urandom_range(0, 9) != 0, $urandom_range(0, 40) == 0);
    idle(10);
    chk("drain_p0", 64'(exp0.size()), 0);
    chk("drain_p1", 64'(exp1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- FIFO_DEPTH, 2, entries per requester queue.
- ROB_ID_W, 5, ROB tag width.
- DATA_W, 32, result width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_in, in, 1, sole clock.
- rst_n_in, in, 1, asynchronous active-low reset.
- rdy_in, in, 1, global pause; all state frozen while low.
- _clear, in, 1, pipeline flush from ROB.
- _req_valid, in, 3, result valid; index 0 ALU, 1 BRU, 2 LSU.
- _req_rob_id, in, 3*ROB_ID_W, packed tags, requester i at [i*5+:5].
- _req_value, in, 3*DATA_W, packed values.
- _req_ready, out, 3, requester i queue can accept.
- _cdb_ready, out, 1, port-0 broadcast valid.
- _cdb_rob_id, out, ROB_ID_W, port-0 tag.
- _cdb_value, out, DATA_W, port-0 value.
- _cdb_ls_ready, out, 1, port-1 broadcast valid.
- _cdb_ls_rob_id, out, ROB_ID_W, port-1 tag.
- _cdb_ls_value, out, DATA_W, port-1 value.

Function
REQ-003 The block SHALL transfer entry i when _req_valid[i] && _req_ready[i] && rdy_in && !_clear at a rising edge, pushing it into queue i.
REQ-004 _req_ready[i] SHALL equal (count_i < FIFO_DEPTH), registered-state only, with no combinational path from the valid inputs or from the grants.
REQ-005 Each cycle, the arbiter SHALL select the port-0 winner from non-empty queue heads in round-robin order starting at rr_ptr.
REQ-006 The arbiter SHALL select the port-1 winner from the remaining non-empty heads of ALU and LSU only, in the same rotation order; BRU results SHALL never use port 1.
REQ-007 At each edge with rdy_in high and no _clear, winners SHALL pop their queues and load the output registers; a port with no winner SHALL have its ready driven 0 and its tag/value held.
REQ-008 Latency SHALL be as follows: an entry accepted into an empty queue at edge k appears on a CDB port after edge k+1 at the earliest, with each broadcast lasting exactly one rdy-high cycle.
REQ-009 Push and pop on the same queue at the same edge SHALL both take effect; count is unchanged.
REQ-010 rr_ptr SHALL range 0..2; after a port-0 grant to g, rr_ptr <= (g==2)?0:g+1; with no port-0 grant, rr_ptr holds.
REQ-011 Per-requester order SHALL be preserved; at most 2 results leave per cycle; no result SHALL be duplicated or dropped except by _clear.
REQ-012 _clear with rdy_in high SHALL do all of the following at the edge: empty all queues, drop same-cycle requests, deassert both ready outputs, and set rr_ptr to 0.
REQ-013 While rdy_in is low, queues, rr_ptr and all outputs SHALL hold, and no transfer SHALL occur.

Reset
REQ-014 rst_n_in low SHALL asynchronously set counts and pointers to 0, rr_ptr to 0, and _cdb_ready/_cdb_ls_ready to 0, with tags and values at 0 and _req_ready reading 3'b111 after release.
REQ-015 Reset asserted mid-broadcast SHALL deassert both ready outputs immediately, without waiting for a clock edge.

Configuration
REQ-016 With macro CDB_ARB_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin per REQ-005/010.
REQ-017 Without CDB_ARB_ROUND_ROBIN_EN, arbitration SHALL use fixed priority LSU > ALU > BRU for port 0 and LSU > ALU for port 1, with rr_ptr absent.

Structure
REQ-018 Package cdb_pkg SHALL hold NUM_REQ=3, REQ_ALU=0, REQ_BRU=1, REQ_LSU=2, ROB_ID_W, DATA_W, and the cdb_entry_t typedef {rob_id, value}.
REQ-019 Per-requester queues SHALL be instances of sub-module cdb_req_fifo (parameterised depth, push/pop/full/empty/head).

Verification
REQ-020 Single ALU push {id 3, 0x0000_0010} at edge 1 -> _cdb_ready=1, id 3, value 0x10 after edge 2, for one cycle only; _cdb_ls_ready=0.
REQ-021 All three push at once (ALU id1, BRU id2, LSU id3), rr_ptr=0 -> port0 ALU id1, port1 LSU id3; next cycle port0 BRU id2; rr_ptr ends 2.
REQ-022 BRU alone with two entries {id 4, id 5} -> both on port 0 on consecutive cycles; _cdb_ls_ready stays 0.
REQ-023 ALU pushes 3 entries with outputs blocked by the LSU/BRU load -> _req_ready[0]=0 after 2 accepted; order id 7, 8, 9 preserved on the CDB.
REQ-024 _clear with 2 queued entries plus a same-cycle request -> no broadcast follows, all _req_ready=1, and a subsequent push of id 6 emerges alone.
REQ-025 rdy_in low for 3 cycles while _cdb_ready=1 with id 9 -> outputs hold id 9; on rdy_in return, id 9 is consumed once, then the next entry follows.
